// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing shared by the sync generator and the downstream
// pixel generators (bricks, paddle, ball).
package vga_timing_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_TICK_DIV  = 4;

  localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // True when value lies in [first, first+len-1]; coordinates are zero-extended.
  function automatic logic inWindow(coord_t value, int first, int len);
    return (int'(value) >= first) && (int'(value) < first + len);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster position and sync bundle from the sync generator to the pixel generators.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  coord_t pixelX;
  coord_t pixelY;
  logic   hsync;
  logic   vsync;
  logic   videoOn;
  logic   pixelTick;
  logic   frameStart;

  modport master (output pixelX, pixelY, hsync, vsync, videoOn, pixelTick, frameStart);
  modport slave  (input  pixelX, pixelY, hsync, vsync, videoOn, pixelTick, frameStart);

endinterface

// File: rtl/pixel_tick_div.sv
// Pixel-rate divider: pixelTick is a flop aligned with the divider's last count.
module pixel_tick_div #(
  parameter int TICK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  output logic pixelTick
);

  localparam logic [2:0] LAST = 3'(TICK_DIV - 1);

  logic [2:0] divCount;
  logic [2:0] divNext;

  always_comb begin
    divNext = (divCount == LAST) ? 3'd0 : divCount + 3'd1;
  end

  // Registering the strobe keeps it low in reset even when TICK_DIV is 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      divCount  <= '0;
      pixelTick <= 1'b0;
    end else begin
      divCount  <= divNext;
      pixelTick <= (divNext == LAST);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster counters with registered sync/videoOn decode taken from the
// next-state counters, so every output moves on the same edge as pixelX/pixelY.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int TICK_DIV  = DEF_TICK_DIV
) (
  input  logic           clock,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam coord_t H_LAST = coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t V_LAST = coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

  logic   tick;
  coord_t xQ, yQ, xNext, yNext;
  logic   frameWrap;
  logic   hsyncQ, vsyncQ, videoOnQ, frameStartQ;

  pixel_tick_div #(.TICK_DIV(TICK_DIV)) uTickDiv (
    .clock     (clock),
    .reset     (reset),
    .pixelTick (tick)
  );

  always_comb begin
    xNext     = xQ;
    yNext     = yQ;
    frameWrap = 1'b0;
    if (tick) begin
      if (xQ == H_LAST) begin
        xNext = '0;
        if (yQ == V_LAST) begin
          yNext     = '0;
          frameWrap = 1'b1;
        end else begin
          yNext = yQ + coord_t'(1);
        end
      end else begin
        xNext = xQ + coord_t'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      xQ          <= '0;
      yQ          <= '0;
      hsyncQ      <= 1'b1;
      vsyncQ      <= 1'b1;
      videoOnQ    <= 1'b0;
      frameStartQ <= 1'b0;
    end else begin
      xQ          <= xNext;
      yQ          <= yNext;
      hsyncQ      <= !inWindow(xNext, H_VISIBLE + H_FRONT, H_SYNC);
      vsyncQ      <= !inWindow(yNext, V_VISIBLE + V_FRONT, V_SYNC);
      videoOnQ    <= inWindow(xNext, 0, H_VISIBLE) && inWindow(yNext, 0, V_VISIBLE);
      frameStartQ <= frameWrap;
    end
  end

  assign vga.pixelX     = xQ;
  assign vga.pixelY     = yQ;
  assign vga.hsync      = hsyncQ;
  assign vga.vsync      = vsyncQ;
  assign vga.videoOn    = videoOnQ;
  assign vga.pixelTick  = tick;
  assign vga.frameStart = frameStartQ;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomized bench for vga_sync_gen against a closed-form raster model
// (position derived from the number of pixel ticks since reset release).
module tb_vga_sync_gen;

  typedef struct packed {
    int hv; int hf; int hs; int hb;
    int vv; int vf; int vs; int vb;
    int d;
  } timing_t;

  typedef struct {
    int x; int y;
    bit hs; bit vs; bit von; bit tick; bit fs;
  } exp_t;

  localparam timing_t T0 = '{hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33, d:4};
  localparam timing_t T1 = '{hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33, d:1};
  localparam timing_t T2 = '{hv:8, hf:2, hs:3, hb:2, vv:6, vf:1, vs:2, vb:2, d:3};

  localparam logic [24:0] RESET_OBS = {10'd0, 10'd0, 5'b11000};

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;

  always #5 clk = ~clk;

  // Clock edges since the most recent reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  vga_sync_gen_if vif0 ();
  vga_sync_gen_if vif1 ();
  vga_sync_gen_if vif2 ();

  vga_sync_gen dut0 (.clock(clk), .reset(rst), .vga(vif0));
  vga_sync_gen #(.TICK_DIV(1)) dut1 (.clock(clk), .reset(rst), .vga(vif1));
  vga_sync_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                 .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
                 .TICK_DIV(3)) dut2 (.clock(clk), .reset(rst), .vga(vif2));

  logic [24:0] obs0, obs1, obs2;
  assign obs0 = {vif0.pixelX, vif0.pixelY, vif0.hsync, vif0.vsync, vif0.videoOn, vif0.pixelTick, vif0.frameStart};
  assign obs1 = {vif1.pixelX, vif1.pixelY, vif1.hsync, vif1.vsync, vif1.videoOn, vif1.pixelTick, vif1.frameStart};
  assign obs2 = {vif2.pixelX, vif2.pixelY, vif2.hsync, vif2.vsync, vif2.videoOn, vif2.pixelTick, vif2.frameStart};

  // Pixel advances completed after k edges: a tick is high in every clock
  // whose edge count m>0 satisfies m mod d == d-1, and advances on the next edge.
  function automatic int ticks_at(longint k, int d);
    if (k <= 0) return 0;
    if (d == 1) return int'(k - 1);
    return int'(k / d);
  endfunction

  function automatic exp_t model(longint k, timing_t t);
    exp_t e;
    int ht, vt, n, np;
    ht = t.hv + t.hf + t.hs + t.hb;
    vt = t.vv + t.vf + t.vs + t.vb;
    n  = ticks_at(k, t.d);
    np = ticks_at(k - 1, t.d);
    e.x    = n % ht;
    e.y    = (n / ht) % vt;
    e.tick = (k > 0) && ((k % t.d) == t.d - 1);
    e.von  = (k > 0) && (e.x < t.hv) && (e.y < t.vv);
    e.hs   = !((e.x >= t.hv + t.hf) && (e.x < t.hv + t.hf + t.hs));
    e.vs   = !((e.y >= t.vv + t.vf) && (e.y < t.vv + t.vf + t.vs));
    e.fs   = (n != np) && (e.x == 0) && (e.y == 0);
    return e;
  endfunction

  function automatic logic [24:0] pack_exp(exp_t e);
    return {10'(e.x), 10'(e.y), e.hs, e.vs, e.von, e.tick, e.fs};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (obs0 !== RESET_OBS) begin
        failures++;
        $display("FAIL reset_dut0 cyc=%0d got=%h want=%h", cyc, obs0, RESET_OBS);
      end
      checks++;
      if (obs1 !== RESET_OBS) begin
        failures++;
        $display("FAIL reset_dut1 cyc=%0d got=%h want=%h", cyc, obs1, RESET_OBS);
      end
      checks++;
      if (obs2 !== RESET_OBS) begin
        failures++;
        $display("FAIL reset_dut2 cyc=%0d got=%h want=%h", cyc, obs2, RESET_OBS);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_startup();
    longint firstTick = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (obs0 !== pack_exp(model(cyc, T0))) begin
        failures++;
        $display("FAIL startup_dut0 cyc=%0d got=%h want=%h", cyc, obs0, pack_exp(model(cyc, T0)));
      end
      checks++;
      if (obs1 !== pack_exp(model(cyc, T1))) begin
        failures++;
        $display("FAIL startup_dut1 cyc=%0d got=%h want=%h", cyc, obs1, pack_exp(model(cyc, T1)));
      end
      if (cyc == 1) begin
        checks++;
        if (vif0.videoOn !== 1'b1) begin
          failures++;
          $display("FAIL first_edge_videoOn got=%b want=1", vif0.videoOn);
        end
      end
      if (vif0.pixelTick === 1'b1 && firstTick < 0) firstTick = cyc;
    end
    checks++;
    if (firstTick != 3) begin
      failures++;
      $display("FAIL first_tick_edge got=%0d want=3", firstTick);
    end
  endtask

  task automatic test_line();
    int hsLowClk = 0;
    for (int i = 0; i < 801 * 4 + 8; i++) begin
      @(negedge clk);
      checks++;
      if (obs0 !== pack_exp(model(cyc, T0))) begin
        failures++;
        $display("FAIL line_dut0 cyc=%0d got=%h want=%h", cyc, obs0, pack_exp(model(cyc, T0)));
      end
      if (vif0.hsync === 1'b0 && vif0.pixelY === 10'd0) hsLowClk++;
    end
    checks++;
    if (hsLowClk != T0.hs * T0.d) begin
      failures++;
      $display("FAIL line_hsync_width got=%0d want=%0d", hsLowClk, T0.hs * T0.d);
    end
  endtask

  task automatic test_div1();
    logic   prevHs = 1'b1;
    longint lastFall = -1;
    int     falls = 0;
    int     lowRun = 0;
    for (int i = 0; i < 1700; i++) begin
      @(negedge clk);
      checks++;
      if (obs1 !== pack_exp(model(cyc, T1))) begin
        failures++;
        $display("FAIL div1_dut1 cyc=%0d got=%h want=%h", cyc, obs1, pack_exp(model(cyc, T1)));
      end
      checks++;
      if (vif1.pixelTick !== 1'b1) begin
        failures++;
        $display("FAIL div1_tick_high cyc=%0d got=%b want=1", cyc, vif1.pixelTick);
      end
      if (prevHs === 1'b1 && vif1.hsync === 1'b0) begin
        if (lastFall >= 0) begin
          checks++;
          if (cyc - lastFall != 800) begin
            failures++;
            $display("FAIL div1_line_period got=%0d want=800", cyc - lastFall);
          end
        end
        lastFall = cyc;
        falls++;
        lowRun = 0;
      end
      if (prevHs === 1'b0 && vif1.hsync === 1'b1 && falls > 0) begin
        checks++;
        if (lowRun != 96) begin
          failures++;
          $display("FAIL div1_hsync_width got=%0d want=96", lowRun);
        end
      end
      if (vif1.hsync === 1'b0) lowRun++;
      prevHs = vif1.hsync;
    end
    checks++;
    if (falls < 2) begin
      failures++;
      $display("FAIL div1_hsync_falls got=%0d want>=2", falls);
    end
  endtask

  task automatic test_frame();
    int     ht = T2.hv + T2.hf + T2.hs + T2.hb;
    int     vt = T2.vv + T2.vf + T2.vs + T2.vb;
    int     frameClk = ht * vt * T2.d;
    longint lastFs = -1;
    int     fsCount = 0;
    int     vonClk = 0;
    int     vsLowClk = 0;
    for (int i = 0; i < 3 * frameClk + 30; i++) begin
      @(negedge clk);
      checks++;
      if (obs2 !== pack_exp(model(cyc, T2))) begin
        failures++;
        $display("FAIL frame_dut2 cyc=%0d got=%h want=%h", cyc, obs2, pack_exp(model(cyc, T2)));
      end
      if (vif2.frameStart === 1'b1) begin
        if (lastFs >= 0) begin
          checks++;
          if (cyc - lastFs != frameClk) begin
            failures++;
            $display("FAIL frame_period got=%0d want=%0d", cyc - lastFs, frameClk);
          end
          checks++;
          if (vonClk != T2.hv * T2.vv * T2.d) begin
            failures++;
            $display("FAIL frame_videoOn_clocks got=%0d want=%0d", vonClk, T2.hv * T2.vv * T2.d);
          end
          checks++;
          if (vsLowClk != T2.vs * ht * T2.d) begin
            failures++;
            $display("FAIL frame_vsync_clocks got=%0d want=%0d", vsLowClk, T2.vs * ht * T2.d);
          end
        end
        lastFs = cyc;
        fsCount++;
        vonClk = 0;
        vsLowClk = 0;
      end
      if (vif2.videoOn === 1'b1) vonClk++;
      if (vif2.vsync === 1'b0) vsLowClk++;
    end
    checks++;
    if (fsCount < 2) begin
      failures++;
      $display("FAIL frame_start_count got=%0d want>=2", fsCount);
    end
  endtask

  task automatic test_reset_mid();
    int target = int'($urandom_range(745, 660));
    bit found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      if (vif0.pixelX === 10'(target)) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reset_mid_reach got=%0d want=%0d", vif0.pixelX, target);
    end
    checks++;
    if (vif0.hsync !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_hsync_before got=%b want=0", vif0.hsync);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs0 !== RESET_OBS) begin
      failures++;
      $display("FAIL reset_mid_async_dut0 got=%h want=%h", obs0, RESET_OBS);
    end
    checks++;
    if (obs1 !== RESET_OBS) begin
      failures++;
      $display("FAIL reset_mid_async_dut1 got=%h want=%h", obs1, RESET_OBS);
    end
    checks++;
    if (obs2 !== RESET_OBS) begin
      failures++;
      $display("FAIL reset_mid_async_dut2 got=%h want=%h", obs2, RESET_OBS);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs0 !== RESET_OBS) begin
        failures++;
        $display("FAIL reset_mid_hold got=%h want=%h", obs0, RESET_OBS);
      end
    end
    rst = 1'b1;
    test_startup();
  endtask

  task automatic test_random_run();
    int n = int'($urandom_range(900, 300));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (obs0 !== pack_exp(model(cyc, T0))) begin
        failures++;
        $display("FAIL run_dut0 cyc=%0d got=%h want=%h", cyc, obs0, pack_exp(model(cyc, T0)));
      end
      checks++;
      if (obs1 !== pack_exp(model(cyc, T1))) begin
        failures++;
        $display("FAIL run_dut1 cyc=%0d got=%h want=%h", cyc, obs1, pack_exp(model(cyc, T1)));
      end
      checks++;
      if (obs2 !== pack_exp(model(cyc, T2))) begin
        failures++;
        $display("FAIL run_dut2 cyc=%0d got=%h want=%h", cyc, obs2, pack_exp(model(cyc, T2)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_line();
    test_div1();
    test_frame();
    test_reset_mid();
    test_random_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
